ball_renderer: RTL and testbench

BALL_RENDERER -- requirements
Module: ball_renderer

---
 rtl/ball_pkg.sv | 21 ++
 rtl/ball_hit.sv | 51 +++++
 rtl/ball_renderer.sv | 134 +++++++++++++
 tb/tb_ball_renderer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types and constants for the ball renderer: ball register layout,
// CTRL address and visible screen limits.
package ball_pkg;

    typedef struct packed {
        logic       enable;
        logic [5:0] radius;
        logic [9:0] y;
        logic [9:0] x;
    } ball_t;

    localparam logic [3:0] CTRL_ADDR = 4'd8;
    localparam int         SCREEN_W  = 640;
    localparam int         SCREEN_H  = 480;

    // Bus view of a ball; reserved bits [30:26] always read back as zero
    function automatic logic [31:0] ball_to_word(input ball_t b);
        return {b.enable, 5'b0, b.radius, b.y, b.x};
    endfunction

endpackage

// File: rtl/ball_hit.sv
// Two-stage distance compare for one ball: stage 1 registers the signed
// offsets, stage 2 registers whether the pixel lies inside the circle.
module ball_hit
    import ball_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  ball_t       ball,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        hit
);

    logic signed [10:0] dx, dy;
    logic               en_q;
    logic [11:0]        r2_q;
    logic               on_screen;
    logic [10:0]        adx, ady;
    logic [20:0]        dist2;

    assign on_screen = (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));

    // Offsets are taken in signed arithmetic, so a ball near one edge never
    // wraps around to hit pixels on the opposite edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dx   <= '0;
            dy   <= '0;
            en_q <= 1'b0;
            r2_q <= '0;
        end else begin
            dx   <= {1'b0, DrawX} - {1'b0, ball.x};
            dy   <= {1'b0, DrawY} - {1'b0, ball.y};
            en_q <= ball.enable && on_screen;
            r2_q <= {6'b0, ball.radius} * {6'b0, ball.radius};
        end
    end

    assign adx   = dx[10] ? -dx : dx;
    assign ady   = dy[10] ? -dy : dy;
    assign dist2 = (21'(adx) * 21'(adx)) + (21'(ady) * 21'(ady));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit <= 1'b0;
        end else begin
            hit <= en_q && (dist2 <= {9'b0, r2_q});
        end
    end

endmodule

// File: rtl/ball_renderer.sv
// Avalon-MM ball register file with vsync-aligned double buffering and a
// per-ball hit pipeline. Optional frame counter: BALL_FRAME_COUNTER_EN.
module ball_renderer
    import ball_pkg::*;
#(
    parameter int NUM_BALLS = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        avl_chipselect,
    input  logic        avl_read,
    input  logic        avl_write,
    input  logic [3:0]  avl_address,
    input  logic [31:0] avl_writedata,
    output logic [31:0] avl_readdata,
    input  logic        VGA_VS,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        is_ball,
    output logic [2:0]  ball_id
);

    ball_t                pend [NUM_BALLS];
    ball_t                act  [NUM_BALLS];
    logic                 commit_pending;
    logic                 vs_s1, vs_s2, vs_s3;
    logic                 vs_fall, swap;
    logic                 wr_en, rd_en, ctrl_commit;
    logic [31:0]          rd_word;
    logic [15:0]          frame_count;
    logic [NUM_BALLS-1:0] hit;
    logic                 unused_wdata;

    assign unused_wdata = &{1'b0, avl_writedata[30:26]};

    assign wr_en       = avl_chipselect && avl_write;
    assign rd_en       = avl_chipselect && avl_read;
    assign ctrl_commit = wr_en && (avl_address == CTRL_ADDR) && avl_writedata[0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_s3 <= 1'b0;
        end else begin
            vs_s1 <= VGA_VS;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    assign vs_fall = vs_s3 && !vs_s2;
    assign swap    = vs_fall && commit_pending;

`ifdef BALL_FRAME_COUNTER_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_count <= '0;
        end else if (vs_fall) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`else
    assign frame_count = '0;
`endif

    always_comb begin
        rd_word = '0;
        if (avl_address == CTRL_ADDR) begin
            rd_word = {frame_count, 15'b0, commit_pending};
        end
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (avl_address == 4'(i)) begin
                rd_word = ball_to_word(pend[i]);
            end
        end
    end

    // A ball write landing on a swap cycle goes to pending only; the active
    // copy takes the pre-write pending value.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
            end
            commit_pending <= 1'b0;
            avl_readdata   <= '0;
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (swap) begin
                    act[i] <= pend[i];
                end
                if (wr_en && (avl_address == 4'(i))) begin
                    pend[i] <= ball_t'{enable: avl_writedata[31],
                                       radius: avl_writedata[25:20],
                                       y:      avl_writedata[19:10],
                                       x:      avl_writedata[9:0]};
                end
            end
            if (ctrl_commit) begin
                commit_pending <= 1'b1;
            end else if (swap) begin
                commit_pending <= 1'b0;
            end
            if (rd_en) begin
                avl_readdata <= rd_word;
            end
        end
    end

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_hit
        ball_hit u_hit (
            .Clk   (Clk),
            .Reset (Reset),
            .ball  (act[g]),
            .DrawX (DrawX),
            .DrawY (DrawY),
            .hit   (hit[g])
        );
    end

    always_comb begin
        is_ball = 1'b0;
        ball_id = 3'd0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                is_ball = 1'b1;
                ball_id = 3'(i);
            end
        end
    end

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer: table-driven pixel vectors per ball
// configuration plus hand-timed sequences for swap coincidences and reset.
module tb_ball_renderer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        avl_chipselect, avl_read, avl_write;
    logic [3:0]  avl_address;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;
    logic        VGA_VS;
    logic [9:0]  DrawX, DrawY;
    logic        is_ball;
    logic [2:0]  ball_id;

    int n_pass  = 0;
    int n_total = 0;
    int n_vs    = 0;

    typedef struct {
        int phase;
        int x;
        int y;
        bit exp_is;
        int exp_id;
    } pix_t;

    pix_t vecs[$];

    ball_renderer #(.NUM_BALLS(4)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .avl_chipselect (avl_chipselect),
        .avl_read       (avl_read),
        .avl_write      (avl_write),
        .avl_address    (avl_address),
        .avl_writedata  (avl_writedata),
        .avl_readdata   (avl_readdata),
        .VGA_VS         (VGA_VS),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .is_ball        (is_ball),
        .ball_id        (ball_id)
    );

    always #10 Clk = ~Clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    function automatic logic [31:0] mk(input bit en, input int x, input int y, input int r);
        return {en, 5'b0, 6'(r), 10'(y), 10'(x)};
    endfunction

    function automatic logic [31:0] ctrl_exp(input bit cp);
        logic [15:0] fc;
`ifdef BALL_FRAME_COUNTER_EN
        fc = 16'(n_vs);
`else
        fc = 16'd0;
`endif
        return {fc, 15'b0, cp};
    endfunction

    task automatic bus_wr(input bit cs, input logic [3:0] a, input logic [31:0] d);
        @(negedge Clk);
        avl_chipselect = cs; avl_write = 1'b1; avl_address = a; avl_writedata = d;
        @(negedge Clk);
        avl_chipselect = 1'b0; avl_write = 1'b0; avl_writedata = '0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge Clk);
        avl_chipselect = 1'b1; avl_read = 1'b1; avl_address = a;
        @(negedge Clk);
        avl_chipselect = 1'b0; avl_read = 1'b0;
        d = avl_readdata;
    endtask

    task automatic pulse_vs();
        @(negedge Clk);
        VGA_VS = 1'b0;
        repeat (4) @(negedge Clk);
        VGA_VS = 1'b1;
        repeat (4) @(negedge Clk);
        n_vs++;
    endtask

    // Bus write timed to land on the same rising edge as the swap
    task automatic pulse_vs_with_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge Clk);
        VGA_VS = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        avl_chipselect = 1'b1; avl_write = 1'b1; avl_address = a; avl_writedata = d;
        @(negedge Clk);
        avl_chipselect = 1'b0; avl_write = 1'b0; avl_writedata = '0;
        repeat (2) @(negedge Clk);
        VGA_VS = 1'b1;
        repeat (4) @(negedge Clk);
        n_vs++;
    endtask

    task automatic pix_check(input int x, input int y, input bit is_e, input int id_e, input string name);
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y);
        @(negedge Clk);
        @(negedge Clk);
        check({name, "_is"}, 32'(is_ball), 32'(is_e));
        check({name, "_id"}, 32'(ball_id), 32'(id_e));
    endtask

    task automatic run_phase(input int p);
        foreach (vecs[k]) begin
            if (vecs[k].phase == p)
                pix_check(vecs[k].x, vecs[k].y, vecs[k].exp_is, vecs[k].exp_id,
                          $sformatf("p%0d_v%0d", p, k));
        end
    endtask

    task automatic add(input int p, input int x, input int y, input bit is_e, input int id_e);
        pix_t v;
        v.phase = p; v.x = x; v.y = y; v.exp_is = is_e; v.exp_id = id_e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] d;

        // ball0 at (100,100) r=10
        add(1, 105, 105, 1, 0);
        add(1, 111, 100, 0, 0);
        add(1, 110, 100, 1, 0);
        add(1, 100,  90, 1, 0);
        add(1, 100,  89, 0, 0);
        add(1,  92,  94, 1, 0);
        add(1,  93,  93, 1, 0);
        add(1,  92,  93, 0, 0);
        add(1,   0,   0, 0, 0);
        // ball0 disabled, ball1 (200,200) r5, ball2 (200,200) r8, ball3 (2,50) r5
        add(2, 200, 200, 1, 1);
        add(2, 205, 200, 1, 1);
        add(2, 207, 200, 1, 2);
        add(2, 209, 200, 0, 0);
        add(2, 400, 400, 0, 0);
        add(2,   2,  50, 1, 3);
        add(2,   0,  50, 1, 3);
        add(2,   7,  50, 1, 3);
        add(2,   8,  50, 0, 0);
        add(2, 637,  50, 0, 0);
        add(2, 639,  50, 0, 0);
        add(2, 100, 100, 0, 0);
        // ball0 enabled at (300,300) r0
        add(3, 300, 300, 1, 0);
        add(3, 301, 300, 0, 0);
        add(3, 300, 299, 0, 0);
        add(3, 203, 204, 1, 1);

        Reset = 1'b1;
        avl_chipselect = 1'b0; avl_read = 1'b0; avl_write = 1'b0;
        avl_address = '0; avl_writedata = '0;
        VGA_VS = 1'b1; DrawX = '0; DrawY = '0;
        repeat (3) @(negedge Clk);
        check("rst_readdata", avl_readdata, 32'h0);
        check("rst_is_ball", 32'(is_ball), 32'h0);
        check("rst_ball_id", 32'(ball_id), 32'h0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        bus_rd(4'd0, d); check("init_ball0", d, 32'h0);
        bus_rd(4'd8, d); check("init_ctrl", d, ctrl_exp(1'b0));

        bus_wr(1'b1, 4'd0, mk(1, 100, 100, 10) | 32'h7C00_0000);
        bus_rd(4'd0, d); check("ball0_rb", d, mk(1, 100, 100, 10));
        bus_wr(1'b0, 4'd0, mk(1, 5, 5, 5));
        check("rd_hold", avl_readdata, mk(1, 100, 100, 10));
        bus_rd(4'd0, d); check("no_cs_ignored", d, mk(1, 100, 100, 10));
        bus_wr(1'b1, 4'd5, 32'hFFFF_FFFF);
        bus_rd(4'd5, d); check("addr5_zero", d, 32'h0);
        bus_wr(1'b1, 4'd9, 32'h1);
        bus_rd(4'd15, d); check("addr15_zero", d, 32'h0);
        bus_wr(1'b1, 4'd8, 32'h0);
        bus_rd(4'd8, d); check("ctrl_wr0", d, ctrl_exp(1'b0));

        pulse_vs();
        pix_check(100, 100, 0, 0, "no_commit");
        bus_rd(4'd8, d); check("no_commit_ctrl", d, ctrl_exp(1'b0));

        bus_wr(1'b1, 4'd8, 32'h1);
        bus_rd(4'd8, d); check("commit_set", d, ctrl_exp(1'b1));
        pulse_vs();
        bus_rd(4'd8, d); check("commit_clr", d, ctrl_exp(1'b0));
        run_phase(1);

        @(negedge Clk);
        DrawX = 10'd105; DrawY = 10'd105;
        @(negedge Clk);
        check("lat1_is", 32'(is_ball), 32'h0);
        @(negedge Clk);
        check("lat2_is", 32'(is_ball), 32'h1);

        bus_wr(1'b1, 4'd0, mk(0, 400, 400, 20));
        bus_wr(1'b1, 4'd1, mk(1, 200, 200, 5));
        bus_wr(1'b1, 4'd2, mk(1, 200, 200, 8));
        bus_wr(1'b1, 4'd3, mk(1, 2, 50, 5));
        bus_wr(1'b1, 4'd8, 32'h1);
        pulse_vs();
        run_phase(2);

        bus_wr(1'b1, 4'd0, mk(1, 300, 300, 0));
        bus_wr(1'b1, 4'd8, 32'h1);
        pulse_vs();
        run_phase(3);

        bus_wr(1'b1, 4'd1, mk(1, 50, 400, 3));
        bus_wr(1'b1, 4'd8, 32'h1);
        pulse_vs_with_wr(4'd1, mk(1, 60, 400, 3));
        pix_check(50, 400, 1, 1, "wr_swap_old");
        pix_check(60, 400, 0, 0, "wr_swap_new");
        bus_rd(4'd1, d); check("wr_swap_pend", d, mk(1, 60, 400, 3));
        bus_rd(4'd8, d); check("wr_swap_ctrl", d, ctrl_exp(1'b0));
        bus_wr(1'b1, 4'd8, 32'h1);
        pulse_vs();
        pix_check(60, 400, 1, 1, "wr_swap_new2");
        pix_check(50, 400, 0, 0, "wr_swap_old2");

        bus_wr(1'b1, 4'd0, mk(1, 500, 300, 4));
        bus_wr(1'b1, 4'd8, 32'h1);
        pulse_vs_with_wr(4'd8, 32'h1);
        pix_check(500, 300, 1, 0, "commit_swap_pix");
        bus_rd(4'd8, d); check("commit_swap_ctrl", d, ctrl_exp(1'b1));
        pulse_vs();
        bus_rd(4'd8, d); check("commit_swap_clr", d, ctrl_exp(1'b0));

        pix_check(500, 300, 1, 0, "pre_reset");
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("midrst_is", 32'(is_ball), 32'h0);
        check("midrst_id", 32'(ball_id), 32'h0);
        check("midrst_rd", avl_readdata, 32'h0);
        n_vs = 0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("post_rst_is", 32'(is_ball), 32'h0);
        for (int a = 0; a < 4; a++) begin
            bus_rd(4'(a), d);
            check($sformatf("post_rst_ball%0d", a), d, 32'h0);
        end
        bus_rd(4'd8, d); check("post_rst_ctrl", d, 32'h0);

        pulse_vs(); pulse_vs(); pulse_vs();
        bus_rd(4'd8, d); check("frame_count3", d, ctrl_exp(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
